// File: rtl/cpu_pkg.sv
// Shared constants for the tiny CPU: fetch FSM state encoding and default address width.
package cpu_pkg;

   localparam int unsigned AddrWidth = 8;

   typedef logic [2:0] state_t;

   localparam state_t StIdle   = 3'd0;
   localparam state_t StAddr   = 3'd1;
   localparam state_t StWait   = 3'd2;
   localparam state_t StLatch  = 3'd3;
   localparam state_t StExec   = 3'd4;
   localparam state_t StHalted = 3'd5;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer handshake bundle; master is the sequencer, slave is memory/execute side.
// The step signal exists only when SINGLE_STEP_EN is defined.
interface fetch_sequencer_if #(
   parameter int unsigned N = cpu_pkg::AddrWidth
);
   logic         run;
   logic         mem_ready;
   logic         exec_done;
   logic         jump;
   logic [N-1:0] jump_addr;
   logic         halt;
`ifdef SINGLE_STEP_EN
   logic         step;
`endif
   logic [N-1:0] mar_data;
   logic         mar_load;
   logic         mem_rd;
   logic         ir_load;
   logic         exec_start;
   logic         busy;
   logic         halted;

   modport master (
      input  run, mem_ready, exec_done, jump, jump_addr, halt,
`ifdef SINGLE_STEP_EN
      input  step,
`endif
      output mar_data, mar_load, mem_rd, ir_load, exec_start, busy, halted
   );

   modport slave (
      output run, mem_ready, exec_done, jump, jump_addr, halt,
`ifdef SINGLE_STEP_EN
      output step,
`endif
      input  mar_data, mar_load, mem_rd, ir_load, exec_start, busy, halted
   );

endinterface

// File: rtl/program_counter.sv
// Program counter register with async reset; load takes priority over increment.
module program_counter #(
   parameter int unsigned N        = 8,
   parameter logic [N-1:0] RESET_PC = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc_i,
   input  logic         load_i,
   input  logic [N-1:0] load_val_i,
   output logic [N-1:0] pc_o
);

   logic [N-1:0] pc_q, pc_d;

   always_comb begin
      pc_d = pc_q;
      if (load_i) begin
         pc_d = load_val_i;
      end else if (inc_i) begin
         pc_d = pc_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: T-state FSM plus PC, Moore-decoded strobes.
// Define SINGLE_STEP_EN to fetch one instruction per rising edge of step instead of run.
module fetch_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned N        = AddrWidth,
   parameter logic [N-1:0] RESET_PC = '0
) (
   input logic                clk,
   input logic                rst,
   fetch_sequencer_if.master  bus_io
);

   state_t       state_q, state_d;
   logic         exec_first_q;
   logic         pc_inc, pc_load;
   logic         start_fetch, keep_running;
   logic [N-1:0] pc;

`ifdef SINGLE_STEP_EN
   logic step_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_q <= 1'b0;
      end else begin
         step_q <= bus_io.step;
      end
   end

   assign start_fetch  = bus_io.step & ~step_q;
   assign keep_running = 1'b0;
`else
   assign start_fetch  = bus_io.run;
   assign keep_running = bus_io.run;
`endif

   always_comb begin
      state_d = state_q;
      pc_inc  = 1'b0;
      pc_load = 1'b0;
      case (state_q)
         StIdle:  if (start_fetch) state_d = StAddr;
         StAddr:  state_d = StWait;
         StWait:  if (bus_io.mem_ready) state_d = StLatch;
         StLatch: begin
            pc_inc  = 1'b1;
            state_d = StExec;
         end
         StExec: begin
            if (bus_io.exec_done) begin
               // halt wins over jump and leaves the PC untouched
               if (bus_io.halt) begin
                  state_d = StHalted;
               end else begin
                  pc_load = bus_io.jump;
                  state_d = keep_running ? StAddr : StIdle;
               end
            end
         end
         StHalted: state_d = StHalted;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         exec_first_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         exec_first_q <= (state_d == StExec) && (state_q != StExec);
      end
   end

   program_counter #(
      .N        (N),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk        (clk),
      .rst        (rst),
      .inc_i      (pc_inc),
      .load_i     (pc_load),
      .load_val_i (bus_io.jump_addr),
      .pc_o       (pc)
   );

   assign bus_io.mar_data   = pc;
   assign bus_io.mar_load   = (state_q == StAddr);
   assign bus_io.mem_rd     = (state_q == StWait);
   assign bus_io.ir_load    = (state_q == StLatch);
   assign bus_io.exec_start = (state_q == StExec) && exec_first_q;
   assign bus_io.busy       = (state_q != StIdle) && (state_q != StHalted);
   assign bus_io.halted     = (state_q == StHalted);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; expected fetch addresses queued and checked on mar_load.
module tb_fetch_sequencer;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   ir_cnt;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   fetch_sequencer_if #(.N(8)) bus ();

   fetch_sequencer #(
      .N        (8),
      .RESET_PC (8'h00)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every address load must match the next queued fetch address.
   always @(posedge clk) begin
      #2;
      if (bus.mar_load === 1'b1) begin
         if (exp_q.size() == 0) check("mar_unexpected", 32'(exp_q.size()), 1);
         else check("mar_data_sb", bus.mar_data, exp_q.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus.run = 0; bus.mem_ready = 0; bus.exec_done = 0;
      bus.jump = 0; bus.jump_addr = 8'h00; bus.halt = 0;
`ifdef SINGLE_STEP_EN
      bus.step = 0;
`endif
      #1;
      check("rst_mar_data", bus.mar_data, 8'h00);
      check("rst_mar_load", bus.mar_load, 0);
      check("rst_mem_rd", bus.mem_rd, 0);
      check("rst_ir_load", bus.ir_load, 0);
      check("rst_exec_start", bus.exec_start, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_halted", bus.halted, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

`ifndef SINGLE_STEP_EN
      // back-to-back 4-cycle instructions
      bus.run = 1; bus.mem_ready = 1; bus.exec_done = 1;
      exp_q.push_back(8'h00); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
      for (int k = 1; k <= 12; k++) begin
         tick();
         check("t1_mar_load", bus.mar_load, 32'(k % 4 == 1));
         check("t1_ir_load", bus.ir_load, 32'(k % 4 == 3));
         check("t1_exec_start", bus.exec_start, 32'(k % 4 == 0));
         check("t1_busy", bus.busy, 1);
         if (k == 12) bus.run = 0;
      end
      tick();
      check("t1_idle_busy", bus.busy, 0);
      check("t1_idle_pc", bus.mar_data, 8'h03);

      // memory stall in WAIT
      bus.mem_ready = 0; bus.exec_done = 0; bus.run = 1;
      exp_q.push_back(8'h03);
      tick();
      tick();
      for (int i = 0; i < 4; i++) begin
         check("t2_mem_rd", bus.mem_rd, 1);
         check("t2_no_ir", bus.ir_load, 0);
         if (i == 3) bus.mem_ready = 1;
         tick();
      end
      check("t2_rd_off", bus.mem_rd, 0);
      check("t2_ir_load", bus.ir_load, 1);
      check("t2_pc_latch", bus.mar_data, 8'h03);
      bus.mem_ready = 0;
      tick();
      check("t2_exec_start", bus.exec_start, 1);
      check("t2_pc_inc", bus.mar_data, 8'h04);
      tick();
      check("t2_exec_hold", bus.exec_start, 0);
      check("t2_busy", bus.busy, 1);
      check("t2_pc_once", bus.mar_data, 8'h04);

      // jump taken with exec_done
      bus.jump = 1; bus.jump_addr = 8'h3C; bus.exec_done = 1;
      exp_q.push_back(8'h3C);
      tick();
      check("t3_mar_load", bus.mar_load, 1);
      check("t3_jump_pc", bus.mar_data, 8'h3C);
      bus.jump = 0; bus.exec_done = 0; bus.mem_ready = 1;
      tick();
      tick();
      tick();
      check("t3_pc_after", bus.mar_data, 8'h3D);
      bus.run = 0; bus.exec_done = 1;
      tick();
      check("t3_stop_busy", bus.busy, 0);
      check("t3_stop_pc", bus.mar_data, 8'h3D);

      // async reset in the middle of WAIT
      bus.mem_ready = 0; bus.exec_done = 0; bus.run = 1;
      exp_q.push_back(8'h3D);
      tick();
      tick();
      check("t5_in_wait", bus.mem_rd, 1);
      rst = 1'b1;
      #1;
      check("t5_rst_mem_rd", bus.mem_rd, 0);
      check("t5_rst_mar_load", bus.mar_load, 0);
      check("t5_rst_busy", bus.busy, 0);
      check("t5_rst_pc", bus.mar_data, 8'h00);
      tick();
      rst = 1'b0;

      // wrap 0xFF -> 0x00, then halt beats jump
      bus.run = 1; bus.mem_ready = 1; bus.exec_done = 1;
      bus.jump = 1; bus.jump_addr = 8'hFF;
      exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
      repeat (5) tick();
      check("t4_mar_load", bus.mar_load, 1);
      check("t4_pc_ff", bus.mar_data, 8'hFF);
      bus.jump = 0; bus.exec_done = 0;
      tick();
      tick();
      check("t4_ir_load", bus.ir_load, 1);
      tick();
      check("t4_wrap", bus.mar_data, 8'h00);
      bus.halt = 1; bus.jump = 1; bus.jump_addr = 8'h55; bus.exec_done = 1;
      tick();
      check("t4_halted", bus.halted, 1);
      check("t4_halt_busy", bus.busy, 0);
      check("t4_halt_pc", bus.mar_data, 8'h00);
      bus.halt = 0; bus.jump = 0;
      repeat (3) tick();
      check("t4_stay_halted", bus.halted, 1);
      check("t4_halt_no_rd", bus.mem_rd, 0);
      check("t4_halt_pc_hold", bus.mar_data, 8'h00);
`else
      // one instruction per step pulse, run level ignored
      bus.run = 1; bus.mem_ready = 1; bus.exec_done = 1;
      exp_q.push_back(8'h00); exp_q.push_back(8'h01);
      ir_cnt = 0;
      for (int p = 0; p < 2; p++) begin
         bus.step = 1;
         tick();
         bus.step = 0;
         for (int i = 0; i < 6; i++) begin
            if (bus.ir_load === 1'b1) ir_cnt++;
            tick();
         end
      end
      check("st_ir_count", 32'(ir_cnt), 2);
      check("st_idle", bus.busy, 0);
      check("st_pc", bus.mar_data, 8'h02);
`endif
      check("sb_drained", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
